// File: rtl/magic_pkg.sv
// Shared types and sizing helpers for the MAGIC NOR in-memory logic engine.
package magic_pkg;

  typedef enum logic [1:0] {
    OP_HALT  = 2'b00,
    OP_INIT1 = 2'b01,
    OP_INV   = 2'b10,
    OP_NOR2  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_DONE
  } state_e;

  localparam int DEF_CELL_W = 6;

  typedef struct packed {
    op_e                   op;
    logic [DEF_CELL_W-1:0] dst;
    logic [DEF_CELL_W-1:0] src_a;
    logic [DEF_CELL_W-1:0] src_b;
  } instr_t;

  function automatic int cell_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int instr_w(input int cw);
    return 2 + 3 * cw;
  endfunction

endpackage

// File: rtl/magic_prog_mem.sv
// Program store: flop array, one write port, async read, resets to HALT.
module magic_prog_mem #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DW    = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/magic_nor_engine.sv
// MAGIC NOR engine: cell row, sequencer FSM and run counters around
// the program store; one instruction per cycle until HALT or end of memory.
module magic_nor_engine
  import magic_pkg::*;
#(
  parameter int NUM_IN     = 10,
  parameter int NUM_CELLS  = 64,
  parameter int PROG_DEPTH = 128,
  localparam int CELL_W  = cell_w(NUM_CELLS),
  localparam int PC_W    = $clog2(PROG_DEPTH),
  localparam int INSTR_W = instr_w(CELL_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  output logic               prog_ready,
  input  logic               in_valid,
  input  logic [NUM_IN-1:0]  in_data,
  output logic               in_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_z,
  output logic               res_err,
  output logic [PC_W:0]      res_cycles
);

  localparam logic [CELL_W:0]  NCELLS  = (CELL_W+1)'(NUM_CELLS);
  localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PROG_DEPTH - 1);

  state_e                 state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [PC_W:0]          cyc_q, cyc_d;
  logic [NUM_CELLS-1:0]   cell_q, cell_d;
  logic                   z_q, z_d;
  logic                   err_q, err_d;

  logic [INSTR_W-1:0]     instr;
  op_e                    op;
  logic [CELL_W-1:0]      dst, src_a, src_b;
  logic                   idle, wr_en, wr_val;
  logic                   v_dst, v_a, v_b;

  magic_prog_mem #(
    .DEPTH (PROG_DEPTH),
    .AW    (PC_W),
    .DW    (INSTR_W)
  ) u_prog (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (prog_we && idle),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .raddr (pc_q),
    .rdata (instr)
  );

  function automatic logic rd(
    input logic [NUM_CELLS-1:0] row,
    input logic [CELL_W-1:0]    idx
  );
    return ({1'b0, idx} < NCELLS) ? row[idx] : 1'b0;
  endfunction

  assign op    = op_e'(instr[INSTR_W-1 -: 2]);
  assign dst   = instr[3*CELL_W-1 -: CELL_W];
  assign src_a = instr[2*CELL_W-1 -: CELL_W];
  assign src_b = instr[CELL_W-1:0];

  // all reads take the pre-update row, so src==dst sees the old value
  assign v_dst = rd(cell_q, dst);
  assign v_a   = rd(cell_q, src_a);
  assign v_b   = rd(cell_q, src_b);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cyc_d   = cyc_q;
    cell_d  = cell_q;
    z_d     = z_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_val  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // vector captured at the handshake so the source may move on
        if (in_valid) begin
          cell_d                = '1;
          cell_d[NUM_IN-1:0]    = in_data;
          state_d               = S_LOAD;
        end
      end
      S_LOAD: begin
        pc_d    = '0;
        cyc_d   = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        cyc_d = cyc_q + (PC_W+1)'(1);
        unique case (1'b1)
          (op == OP_HALT): begin
            z_d     = v_a;
            err_d   = 1'b0;
            state_d = S_DONE;
          end
          (op == OP_INIT1): begin
            wr_en  = 1'b1;
            wr_val = 1'b1;
          end
          (op == OP_INV): begin
            wr_en  = 1'b1;
            wr_val = v_dst & ~v_a;
          end
          (op == OP_NOR2): begin
            wr_en  = 1'b1;
            wr_val = v_dst & ~(v_a | v_b);
          end
          default: ;
        endcase
        if (op != OP_HALT) begin
          if (pc_q == PC_LAST) begin
            z_d     = 1'b0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
        if (wr_en && ({1'b0, dst} < NCELLS)) cell_d[dst] = wr_val;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cyc_q   <= '0;
      cell_q  <= '0;
      z_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
      cell_q  <= cell_d;
      z_q     <= z_d;
      err_q   <= err_d;
    end
  end

  assign idle       = (state_q == S_IDLE);
  assign in_ready   = idle;
  assign prog_ready = idle;
  assign res_valid  = (state_q == S_DONE);
  assign res_z      = z_q;
  assign res_err    = err_q;
  assign res_cycles = cyc_q;

endmodule

// File: doc/magic_nor_engine.md
MAGIC_NOR_ENGINE -- requirements
Module: magic_nor_engine

Interface
REQ-001 Parameters SHALL be: NUM_IN, default 10, count of primary inputs; NUM_CELLS, default 64, count of memristor-row cells; PROG_DEPTH, default 128, number of instruction slots.
REQ-002 Derived constants SHALL be CELL_W = clog2(NUM_CELLS), PC_W = clog2(PROG_DEPTH), INSTR_W = 2 + 3*CELL_W (20 at defaults).
REQ-003 Ports, in this order:
  - clk  in  1  sole clock, rising edge
  - rst_n  in  1  asynchronous, active-low reset
  - prog_we  in  1  program-write strobe
  - prog_addr  in  PC_W  program slot
  - prog_wdata  in  INSTR_W  instruction {op, dst, srcA, srcB}
  - prog_ready  out  1  high when program writes are accepted
  - in_valid  in  1  input vector offered
  - in_data  in  NUM_IN  primary inputs x0..x(NUM_IN-1)
  - in_ready  out  1  engine can accept a vector
  - res_valid  out  1  result available
  - res_ready  in  1  consumer accepts result
  - res_z  out  1  evaluated output bit
  - res_err  out  1  run ended without HALT
  - res_cycles  out  PC_W+1  instructions executed, HALT included

Function
REQ-004 Opcodes SHALL be HALT=00, INIT1=01, INV=10, NOR2=11.
REQ-005 The FSM SHALL have states IDLE, LOAD, EXEC and DONE.
REQ-006 In IDLE, in_ready=1 and prog_ready=1; in all other states both SHALL be 0.
REQ-007 A program write SHALL take effect only when prog_we && prog_ready; at any other time prog_we SHALL be ignored.
REQ-008 in_valid && in_ready SHALL move IDLE->LOAD; a program write in the same cycle SHALL also be accepted.
REQ-009 LOAD (one cycle) SHALL set cell[i]=in_data[i] for i<NUM_IN and cell[i]=1 for every other i, clear PC and the cycle counter, then go to EXEC.
REQ-010 EXEC SHALL execute one instruction per cycle at PC and then increment PC and res_cycles.
REQ-011 INIT1 SHALL set cell[dst]=1.
REQ-012 INV SHALL set cell[dst]=cell[dst] & ~cell[srcA].
REQ-013 NOR2 SHALL set cell[dst]=cell[dst] & ~(cell[srcA]|cell[srcB]); this is the MAGIC conditional-reset rule, so an uninitialised 0 destination stays 0.
REQ-014 srcA==dst or srcB==dst SHALL use the pre-update value of cell[dst].
REQ-015 Cell indices >= NUM_CELLS SHALL read as 0, and writes to them SHALL be dropped.
REQ-016 HALT SHALL latch res_z=cell[srcA], latch res_err=0, count itself in res_cycles, and go to DONE.
REQ-017 If the instruction at PC=PROG_DEPTH-1 is not HALT, it SHALL execute, and then the engine SHALL latch res_err=1 and res_z=0 and go to DONE; PC SHALL never wrap.
REQ-018 In DONE, res_valid=1, and res_z, res_err and res_cycles SHALL be held stable until res_ready.
REQ-019 res_valid && res_ready SHALL move DONE->IDLE, with the result outputs holding their values until the next run.
REQ-020 Latency from vector accept to res_valid SHALL be 2 + (index of HALT) cycles.
REQ-021 The cell array SHALL persist between runs, apart from the LOAD overwrite.
REQ-022 Program memory SHALL persist across runs.

Reset
REQ-023 On rst_n low, the state SHALL be IDLE, and PC, cells, res_z, res_err and res_cycles SHALL be 0.
REQ-024 Every program slot SHALL reset to all-zero, which encodes HALT.
REQ-025 On rst_n low, res_valid SHALL be 0, and in_ready and prog_ready SHALL be 1 once rst_n is released.
REQ-026 Reset asserted mid-EXEC or mid-DONE SHALL abandon the run, with no res_valid pulse.

Structure
REQ-027 The package magic_pkg SHALL hold the opcode enum, the state enum, the instruction struct {op, dst, srcA, srcB} and the INSTR_W/CELL_W functions.
REQ-028 The single sub-module magic_prog_mem SHALL be a PROG_DEPTH x INSTR_W flop array with one write port, one asynchronous read port and async reset to HALT.
REQ-029 The cell row, FSM and counters SHALL reside in magic_nor_engine.

Verification
REQ-030 Program NOR2 c10=c0,c1 then HALT srcA=10, with in_data x0=1, x1=0 -> res_z=0, res_cycles=2, res_valid 3 cycles after accept.
REQ-031 Program INV c12=c3 then HALT srcA=12, with x3=0 -> res_z=1; repeat with x3=1 -> res_z=0.
REQ-032 Program NOR2 c20=c0,c1 (x0=x1=0), NOR2 c20=c2,c2 (x2=0), HALT srcA=20, then the same without the first NOR2 plus x0=1 on the first op -> MAGIC AND rule holds; cases: INIT1 c20 between ops restores 1, omitted INIT1 leaves 0.
REQ-033 Fill all PROG_DEPTH slots with INIT1 -> res_err=1, res_z=0, res_cycles=PROG_DEPTH.
REQ-034 Hold res_ready=0 for 5 cycles in DONE -> res_valid and outputs stable, in_ready=0, prog_we ignored; res_ready=1 -> IDLE next cycle.
REQ-035 Pull rst_n low during EXEC -> IDLE, outputs 0, program cleared to HALT; the next run returns res_cycles=1.
